// File: rtl/ifu_pkg.sv
// ifu_pkg: fetch-state encoding and the opcode constants shared
// between the fetch unit and the control unit.
package ifu_pkg;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_HALTED
  } fetch_state_e;

  // Opcode occupies the top OPC_W bits of every instruction word.
  localparam int unsigned OPC_W = 4;

  localparam logic [OPC_W-1:0] OPC_ADD  = 4'b0000;
  localparam logic [OPC_W-1:0] OPC_SUB  = 4'b0001;
  localparam logic [OPC_W-1:0] OPC_HALT = 4'b1111;

endpackage

// File: rtl/ifu_prefetch_fifo.sv
// ifu_prefetch_fifo: 2-deep word buffer between memory response and
// the downstream instruction handshake (IFU_PREFETCH_EN builds only).
module ifu_prefetch_fifo
  import ifu_pkg::*;
#(
  parameter int unsigned DW = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output logic [DW-1:0] data_o,
  output logic [1:0]    count_o,
  output logic          empty_o
);

  logic [DW-1:0] mem_q [2];
  logic          wr_q;
  logic          rd_q;
  logic [1:0]    cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else if (flush_i) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= ~wr_q;
      end
      if (pop_i) begin
        rd_q <= ~rd_q;
      end
      cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == 2'd0);

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC sequencer, single-outstanding imem fetch and
// instruction handshake. IFU_PREFETCH_EN adds a 2-entry prefetch FIFO.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int unsigned       PC_W     = 8,
  parameter int unsigned       INSTR_W  = 16,
  parameter logic [PC_W-1:0]   RESET_PC = '0,
  parameter logic [OPC_W-1:0]  HALT_OPC = OPC_HALT
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [OPC_W-1:0]   opcode,
  output logic [PC_W-1:0]    instr_pc,
  output logic               halted
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic            req_q, req_d;
  logic            drop_q, drop_d;
  logic            halted_q, halted_d;
  logic            gnt_fire;
  logic            in_flight;

  assign gnt_fire  = req_q & imem_gnt;
  // A response is still owed unless it is arriving right now.
  assign in_flight = gnt_fire |
                     ((state_q == S_WAIT) & ~imem_rvalid);

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign halted    = halted_q;
  assign opcode    = instr[INSTR_W-1 -: OPC_W];

`ifdef IFU_PREFETCH_EN

  localparam int unsigned DW = PC_W + INSTR_W;

  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic [1:0]    fifo_cnt;
  logic [1:0]    cnt_next;
  logic [DW-1:0] head;

  assign push = (state_q == S_WAIT) & imem_rvalid &
                ~drop_q & ~redirect_valid;
  assign pop  = ~fifo_empty & instr_ready;

  ifu_prefetch_fifo #(
    .DW (DW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect_valid),
    .push_i  (push),
    .data_i  ({fetch_pc_q, imem_rdata}),
    .pop_i   (pop),
    .data_o  (head),
    .count_o (fifo_cnt),
    .empty_o (fifo_empty)
  );

  assign instr_valid = ~fifo_empty;
  assign instr       = head[INSTR_W-1:0];
  assign instr_pc    = head[DW-1 -: PC_W];

  assign cnt_next = redirect_valid ? 2'd0 :
                    fifo_cnt + {1'b0, push} - {1'b0, pop};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    halted_d   = halted_q;
    unique case (state_q)
      S_REQ: begin
        if (gnt_fire) begin
          fetch_pc_d = pc_q;
          pc_d       = pc_q + 1'b1;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else if (imem_rdata[INSTR_W-1 -: OPC_W] == HALT_OPC) begin
            state_d = S_HALTED;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_HOLD:   state_d = S_REQ;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_REQ;
    endcase
    if (pop && (instr[INSTR_W-1 -: OPC_W] == HALT_OPC)) begin
      halted_d = 1'b1;
    end
    if (redirect_valid) begin
      pc_d     = redirect_pc;
      halted_d = 1'b0;
      if (in_flight) begin
        drop_d  = 1'b1;
        state_d = S_WAIT;
      end else begin
        drop_d  = 1'b0;
        state_d = S_REQ;
      end
    end
    req_d = (state_d == S_REQ) && (cnt_next != 2'd2);
  end

`else

  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    ipc_q, ipc_d;
  logic               valid_q, valid_d;
  logic               accept;

  assign accept      = valid_q & instr_ready;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    instr_d    = instr_q;
    ipc_d      = ipc_q;
    valid_d    = valid_q;
    unique case (state_q)
      S_REQ: begin
        if (gnt_fire) begin
          fetch_pc_d = pc_q;
          pc_d       = pc_q + 1'b1;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            instr_d = imem_rdata;
            ipc_d   = fetch_pc_q;
            valid_d = 1'b1;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (accept) begin
          valid_d = 1'b0;
          state_d = (opcode == HALT_OPC) ? S_HALTED : S_REQ;
        end
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_REQ;
    endcase
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      valid_d = 1'b0;
      instr_d = instr_q;
      ipc_d   = ipc_q;
      if (in_flight) begin
        drop_d  = 1'b1;
        state_d = S_WAIT;
      end else begin
        drop_d  = 1'b0;
        state_d = S_REQ;
      end
    end
    req_d    = (state_d == S_REQ);
    halted_d = (state_d == S_HALTED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= '0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
    end
  end

`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      fetch_pc_q <= '0;
      req_q      <= 1'b0;
      drop_q     <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      req_q      <= req_d;
      drop_q     <= drop_d;
      halted_q   <= halted_d;
    end
  end

endmodule
